// File: rtl/unstacker_pkg.sv
// Shared constants and FSM state type for the phrase-to-byte unstacker.
package unstacker_pkg;

   localparam int PHRASE_BITS      = 128;
   localparam int PIXEL_BITS       = 8;
   localparam int BYTES_PER_PHRASE = 16;
   localparam int IDX_BITS         = $clog2(BYTES_PER_PHRASE);
   localparam int ENTRY_BITS       = PHRASE_BITS + 1;

   localparam logic [IDX_BITS-1:0] LAST_IDX   = IDX_BITS'(BYTES_PER_PHRASE - 1);
   localparam logic [IDX_BITS-1:0] PENULT_IDX = IDX_BITS'(BYTES_PER_PHRASE - 2);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/phrase_fifo.sv
// Small FIFO of {tlast, phrase} entries; ready is derived purely from the occupancy register.
module phrase_fifo
   import unstacker_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ENTRY_BITS-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_en,
   output logic [ENTRY_BITS-1:0] rd_data
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   logic [ENTRY_BITS-1:0] mem_r [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  push_s;
   logic                  pop_s;

   assign wr_ready = (count_r < DEPTH_C);
   assign rd_valid = (count_r != {CNT_W{1'b0}});
   assign push_s   = wr_valid && wr_ready;
   assign pop_s    = rd_en && rd_valid;
   assign rd_data  = mem_r[rd_ptr_r];

   // Entry storage; contents are don't-care until written so no reset is needed.
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/unstacker.sv
// Serializes 128-bit phrases into an LSB-first byte stream with frame tlast.
// Optional frame counter port enabled by defining UNSTACKER_STATS_EN.
module unstacker
   import unstacker_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   chunk_tvalid,
   output logic                   chunk_tready,
   input  logic [PHRASE_BITS-1:0] chunk_tdata,
   input  logic                   chunk_tlast,
   output logic                   pixel_tvalid,
   input  logic                   pixel_tready,
   output logic [PIXEL_BITS-1:0]  pixel_tdata,
   output logic                   pixel_tlast
`ifdef UNSTACKER_STATS_EN
   ,
   output logic [15:0]            frame_count
`endif
);

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [IDX_BITS-1:0]     idx_r;
   logic [PHRASE_BITS-1:0]  shift_r;
   logic                    phrase_last_r;
   logic                    tvalid_r;
   logic                    tlast_r;
   logic                    fifo_valid_s;
   logic [ENTRY_BITS-1:0]   fifo_data_s;
   logic                    xfer_s;
   logic                    at_last_s;
   logic                    load_s;
   logic                    shift_s;
   logic                    drain_s;

   phrase_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .wr_valid (chunk_tvalid),
      .wr_ready (chunk_tready),
      .wr_data  ({chunk_tlast, chunk_tdata}),
      .rd_valid (fifo_valid_s),
      .rd_en    (load_s),
      .rd_data  (fifo_data_s)
   );

   assign xfer_s       = tvalid_r && pixel_tready;
   assign at_last_s    = (idx_r == LAST_IDX);
   assign pixel_tvalid = tvalid_r;
   assign pixel_tdata  = shift_r[PIXEL_BITS-1:0];
   assign pixel_tlast  = tlast_r;

   // FSM state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: leave SHIFT only when the final byte goes out with nothing queued.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (fifo_valid_s) state_nxt_s = ST_SHIFT;
            else              state_nxt_s = ST_IDLE;
         end
         ST_SHIFT: begin
            if (xfer_s && at_last_s && !fifo_valid_s) state_nxt_s = ST_IDLE;
            else                                       state_nxt_s = ST_SHIFT;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath controls; a last-byte transfer reloads in the same edge to avoid a bubble.
   always_comb begin
      load_s  = 1'b0;
      shift_s = 1'b0;
      drain_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            load_s = fifo_valid_s;
         end
         ST_SHIFT: begin
            if (xfer_s && at_last_s) begin
               load_s  = fifo_valid_s;
               drain_s = !fifo_valid_s;
            end else begin
               shift_s = xfer_s;
            end
         end
         default: begin
            load_s  = 1'b0;
            shift_s = 1'b0;
            drain_s = 1'b0;
         end
      endcase
   end

   // Shift register, byte index and registered stream outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         shift_r       <= {PHRASE_BITS{1'b0}};
         idx_r         <= {IDX_BITS{1'b0}};
         phrase_last_r <= 1'b0;
         tvalid_r      <= 1'b0;
         tlast_r       <= 1'b0;
      end else if (load_s) begin
         shift_r       <= fifo_data_s[PHRASE_BITS-1:0];
         phrase_last_r <= fifo_data_s[PHRASE_BITS];
         idx_r         <= {IDX_BITS{1'b0}};
         tvalid_r      <= 1'b1;
         tlast_r       <= 1'b0;
      end else if (shift_s) begin
         shift_r <= {{PIXEL_BITS{1'b0}}, shift_r[PHRASE_BITS-1:PIXEL_BITS]};
         idx_r   <= idx_r + IDX_BITS'(1);
         tlast_r <= (idx_r == PENULT_IDX) && phrase_last_r;
      end else if (drain_s) begin
         idx_r    <= {IDX_BITS{1'b0}};
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
      end else begin
         shift_r <= shift_r;
         idx_r   <= idx_r;
      end
   end

`ifdef UNSTACKER_STATS_EN
   // Completed-frame counter, wraps at 16 bits.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         frame_count <= 16'h0000;
      end else if (xfer_s && tlast_r) begin
         frame_count <= frame_count + 16'h0001;
      end else begin
         frame_count <= frame_count;
      end
   end
`endif

endmodule

// File: tb/tb_unstacker.sv
// Self-checking bench for unstacker: vector table plus multi-cycle corner sequences.
module tb_unstacker;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic         chunk_tvalid;
   logic         chunk_tready;
   logic [127:0] chunk_tdata;
   logic         chunk_tlast;
   logic         pixel_tvalid;
   logic         pixel_tready;
   logic [7:0]   pixel_tdata;
   logic         pixel_tlast;
`ifdef UNSTACKER_STATS_EN
   logic [15:0]  frame_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   unstacker #(.BUF_DEPTH(2)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .chunk_tvalid (chunk_tvalid),
      .chunk_tready (chunk_tready),
      .chunk_tdata  (chunk_tdata),
      .chunk_tlast  (chunk_tlast),
      .pixel_tvalid (pixel_tvalid),
      .pixel_tready (pixel_tready),
      .pixel_tdata  (pixel_tdata),
      .pixel_tlast  (pixel_tlast)
`ifdef UNSTACKER_STATS_EN
      ,
      .frame_count  (frame_count)
`endif
   );

   typedef struct {
      logic         cv;
      logic [127:0] cd;
      logic         cl;
      logic         pr;
      logic         e_ctr;
      logic         e_pv;
      logic [7:0]   e_pd;
      logic         e_pl;
   } vec_t;

   vec_t vecs[$];

   localparam logic [127:0] P_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] P_TOG = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
   localparam logic [127:0] P_A   = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
   localparam logic [127:0] P_B   = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
   localparam logic [127:0] P_C   = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] p, input int b);
      return p[b*8 +: 8];
   endfunction

   task automatic do_reset();
      rst_in       = 1'b1;
      chunk_tvalid = 1'b0;
      chunk_tdata  = '0;
      chunk_tlast  = 1'b0;
      pixel_tready = 1'b0;
      step();
      step();
      rst_in = 1'b0;
   endtask

   // Hold a phrase on the input until the DUT takes it (bounded).
   task automatic offer(input logic [127:0] d, input logic tl);
      int k;
      chunk_tvalid = 1'b1;
      chunk_tdata  = d;
      chunk_tlast  = tl;
      for (k = 0; k < 50; k++) begin
         if (chunk_tready) break;
         step();
      end
      chk("offer accepted", chunk_tready, 1);
      step();
      chunk_tvalid = 1'b0;
   endtask

   // One phrase into an idle DUT: accept edge, load edge, 16 bytes, then idle.
   task automatic add_phrase(input logic [127:0] p, input logic tl, input bit toggle);
      vec_t v;
      int   b = 0;
      int   s = 0;
      v.cv = 1'b1; v.cd = p; v.cl = tl; v.pr = 1'b1;
      v.e_ctr = 1'b1; v.e_pv = 1'b0; v.e_pd = 8'h00; v.e_pl = 1'b0;
      vecs.push_back(v);
      v.cv = 1'b0;
      vecs.push_back(v);
      while (b < 16) begin
         v.pr   = toggle ? ((s % 2) == 0) : 1'b1;
         v.e_pv = 1'b1;
         v.e_pd = byte_of(p, b);
         v.e_pl = (b == 15) && tl;
         vecs.push_back(v);
         if (v.pr) b++;
         s++;
      end
      v.pr = 1'b1; v.e_pv = 1'b0; v.e_pl = 1'b0;
      vecs.push_back(v);
   endtask

   initial begin
      logic [127:0] phr [3];
      int   p;
      int   got;
      int   gap;
      bit   started;
      bit   seen_low;
      bit   accept;
      int   k;

      add_phrase(P_SEQ, 1'b1, 1'b0);
      add_phrase(P_TOG, 1'b0, 1'b1);

      // Reset values while reset is held.
      do_reset();
      rst_in = 1'b1;
      step();
      chk("rst pixel_tvalid", pixel_tvalid, 0);
      chk("rst pixel_tdata", pixel_tdata, 0);
      chk("rst pixel_tlast", pixel_tlast, 0);
      chk("rst chunk_tready", chunk_tready, 1);
      rst_in = 1'b0;

      foreach (vecs[i]) begin
         chunk_tvalid = vecs[i].cv;
         chunk_tdata  = vecs[i].cd;
         chunk_tlast  = vecs[i].cl;
         pixel_tready = vecs[i].pr;
         chk($sformatf("vec%0d chunk_tready", i), chunk_tready, vecs[i].e_ctr);
         chk($sformatf("vec%0d pixel_tvalid", i), pixel_tvalid, vecs[i].e_pv);
         chk($sformatf("vec%0d pixel_tlast", i), pixel_tlast, vecs[i].e_pl);
         if (vecs[i].e_pv) chk($sformatf("vec%0d pixel_tdata", i), pixel_tdata, vecs[i].e_pd);
         step();
      end

      // Three phrases back-to-back, downstream always ready.
      do_reset();
      phr[0] = P_A; phr[1] = P_B; phr[2] = P_C;
      p = 0; got = 0; gap = 0; started = 0; seen_low = 0;
      pixel_tready = 1'b1;
      for (int cyc = 0; cyc < 120 && got < 48; cyc++) begin
         chunk_tvalid = (p < 3);
         chunk_tdata  = phr[(p < 3) ? p : 0];
         chunk_tlast  = (p == 2);
         accept = chunk_tvalid && chunk_tready;
         if (!chunk_tready) seen_low = 1'b1;
         if (pixel_tvalid) begin
            chk($sformatf("b2b byte%0d", got), pixel_tdata, byte_of(phr[got / 16], got % 16));
            chk($sformatf("b2b last%0d", got), pixel_tlast, (got == 47));
            got++;
            started = 1'b1;
         end else if (started) begin
            gap++;
         end
         step();
         if (accept) p++;
      end
      chunk_tvalid = 1'b0;
      chk("b2b byte count", got, 48);
      chk("b2b bubbles", gap, 0);
      chk("b2b ready dropped", seen_low, 1);
      chk("b2b idle after", pixel_tvalid, 0);

      // Downstream stalled while three phrases are offered.
      do_reset();
      offer(P_A, 1'b0);
      offer(P_B, 1'b0);
      offer(P_C, 1'b1);
      chk("stall ready low", chunk_tready, 0);
      chk("stall valid", pixel_tvalid, 1);
      chk("stall byte0", pixel_tdata, byte_of(P_A, 0));
      step(); step(); step();
      chk("stall held data", pixel_tdata, byte_of(P_A, 0));
      chk("stall held ready", chunk_tready, 0);
      pixel_tready = 1'b1;
      for (int b = 0; b < 16; b++) begin
         chk($sformatf("stall A byte%0d", b), pixel_tdata, byte_of(P_A, b));
         chk($sformatf("stall ready%0d", b), chunk_tready, 0);
         step();
      end
      chk("stall ready after byte15", chunk_tready, 1);
      chk("stall B no bubble", pixel_tvalid, 1);
      chk("stall B byte0", pixel_tdata, byte_of(P_B, 0));

      // Reset mid-phrase discards the active and buffered phrases.
      do_reset();
      offer(P_A, 1'b0);
      offer(P_B, 1'b0);
      pixel_tready = 1'b1;
      for (int b = 0; b < 6; b++) begin
         chk($sformatf("mid A byte%0d", b), pixel_tdata, byte_of(P_A, b));
         step();
      end
      #2;
      rst_in = 1'b1;
      #1;
      chk("mid rst valid", pixel_tvalid, 0);
      chk("mid rst data", pixel_tdata, 0);
      chk("mid rst last", pixel_tlast, 0);
      step();
      rst_in = 1'b0;
      step(); step(); step();
      chk("mid no stale B", pixel_tvalid, 0);
      offer(P_C, 1'b1);
      for (k = 0; k < 10; k++) begin
         if (pixel_tvalid) break;
         step();
      end
      chk("mid C appears", pixel_tvalid, 1);
      for (int b = 0; b < 16; b++) begin
         chk($sformatf("mid C byte%0d", b), pixel_tdata, byte_of(P_C, b));
         step();
      end
      chk("mid idle after C", pixel_tvalid, 0);

`ifdef UNSTACKER_STATS_EN
      do_reset();
      chk("stats reset", frame_count, 0);
      pixel_tready = 1'b1;
      for (int f = 0; f < 4; f++) offer(P_SEQ, 1'b1);
      for (int c = 0; c < 80; c++) step();
      chk("stats four frames", frame_count, 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
